// File: rtl/fifo_wr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_sched_pkg
//  Purpose  : Shared types and constants for the FIFO write-side scheduler.
//             Scheduler states, requester identities and per-requester
//             message lengths in FIFO words.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_wr_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_RF  = 1'b1
    } req_t;

    localparam int ALU_MSG_BYTES = 2;
    localparam int RF_MSG_BYTES  = 1;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-input round-robin arbiter. A lone request is granted
//             directly; on a tie the input that did not win last time wins.
//             The last-grant register advances only when i_update is high.
//  Ports    : clk       - clock
//             rst_n     - synchronous active-low reset
//             i_req     - request vector, bit 0 / bit 1
//             i_update  - a grant was consumed this cycle, remember it
//             o_grant   - one-hot grant (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2 #(
    // Reset value of the last-grant register; 1 lets input 0 win the first tie.
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // 0: input 0 was granted last, 1: input 1 was granted last
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= RESET_LAST;
        end else if (i_update && (o_grant != 2'b00)) begin
            r_last <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_sched
//  Purpose  : Write-side scheduler for the asynchronous FIFO. Arbitrates the
//             ALU result path (2-word message) and the register-file read
//             path (1-word message) round-robin, latches the granted message
//             and serializes it LSB first into FIFO writes, never writing
//             while the FIFO is full.
//  Ports    : CLK         - write-domain clock
//             RST         - synchronous active-low reset
//             ALU_OUT     - ALU message, held while ALU_VLD
//             ALU_VLD     - ALU message valid
//             ALU_RDY     - ALU message accepted this cycle
//             RF_RD_DATA  - register-file message, held while RF_VLD
//             RF_VLD      - RF message valid
//             RF_RDY      - RF message accepted this cycle
//             FIFO_FULL   - FIFO full flag (write domain)
//             WR_DATA     - FIFO write data
//             WR_INC      - FIFO write strobe, one word per high cycle
//             BUSY        - a message is being serialized
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_VLD,
    output logic                    ALU_RDY,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_VLD,
    output logic                    RF_RDY,
    input  logic                    FIFO_FULL,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    WR_INC,
    output logic                    BUSY
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2*DATA_WIDTH-1:0] r_buf;
    logic [1:0]              r_cnt;
    logic [1:0]              w_grant;
    logic                    w_accept;

    // Bit index of each requester in the arbiter matches its req_t encoding.
    rr_arb2 #(
        .RESET_LAST (REQ_RF)
    ) u_arb (
        .clk      (CLK),
        .rst_n    (RST),
        .i_req    ({RF_VLD, ALU_VLD}),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshakes and the write strobe are masked while reset is held so
    // that nothing is accepted or written on an edge that resets the block.
    always_comb begin
        w_state_nxt = r_state;
        ALU_RDY     = 1'b0;
        RF_RDY      = 1'b0;
        WR_INC      = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            IDLE: begin
                ALU_RDY = RST & ALU_VLD & w_grant[REQ_ALU];
                RF_RDY  = RST & RF_VLD  & w_grant[REQ_RF];
                if (ALU_RDY || RF_RDY) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                BUSY   = 1'b1;
                WR_INC = RST & ~FIFO_FULL;
                if (WR_INC && (r_cnt == 2'd1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = ALU_RDY | RF_RDY;
    assign WR_DATA  = r_buf[DATA_WIDTH-1:0];

    // Message buffer: loaded on acceptance, shifted right one word per write
    // so WR_DATA always presents the next unwritten word and is zero once
    // the message is exhausted.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_buf <= '0;
            r_cnt <= 2'd0;
        end else if (ALU_RDY) begin
            r_buf <= ALU_OUT;
            r_cnt <= 2'(ALU_MSG_BYTES);
        end else if (RF_RDY) begin
            r_buf <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            r_cnt <= 2'(RF_MSG_BYTES);
        end else if (WR_INC) begin
            r_buf <= r_buf >> DATA_WIDTH;
            r_cnt <= r_cnt - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_sched
//  Purpose  : Self-checking bench for fifo_wr_sched. A message-level model
//             (pending word queue, busy flag, last winner) predicts the
//             outputs every cycle; directed scenarios then check the written
//             word order, and a small behavioural FIFO with a slower reader
//             exercises back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_sched;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          CLK = 1'b0;
    logic          RCLK = 1'b0;
    logic          RST;
    logic [2*DW-1:0] ALU_OUT;
    logic          ALU_VLD;
    logic          ALU_RDY;
    logic [DW-1:0] RF_RD_DATA;
    logic          RF_VLD;
    logic          RF_RDY;
    logic          full_drv;
    logic          FIFO_FULL;
    logic [DW-1:0] WR_DATA;
    logic          WR_INC;
    logic          BUSY;

    fifo_wr_sched #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ALU_OUT    (ALU_OUT),
        .ALU_VLD    (ALU_VLD),
        .ALU_RDY    (ALU_RDY),
        .RF_RD_DATA (RF_RD_DATA),
        .RF_VLD     (RF_VLD),
        .RF_RDY     (RF_RDY),
        .FIFO_FULL  (FIFO_FULL),
        .WR_DATA    (WR_DATA),
        .WR_INC     (WR_INC),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;
    always begin
        #12 RCLK = 1'b1;
        #13 RCLK = 1'b0;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit             m_busy    = 1'b0;
    bit             m_last_rf = 1'b1;
    logic [DW-1:0]  m_q[$];
    logic [DW-1:0]  m_log[$];
    int             stall_cycles = 0;

    // Observed writes and the behavioural FIFO
    logic [DW-1:0]  dut_log[$];
    bit             fifo_mode = 1'b0;
    int             wr_count = 0;
    int             rd_count = 0;
    logic [DW-1:0]  mem [0:255];
    logic [DW-1:0]  rx[$];

    assign FIFO_FULL = fifo_mode ? ((wr_count - rd_count) >= DEPTH) : full_drv;

    always @(posedge CLK) begin
        if (WR_INC === 1'b1) dut_log.push_back(WR_DATA);
        if (fifo_mode && WR_INC === 1'b1) begin
            mem[wr_count[7:0]] <= WR_DATA;
            wr_count           <= wr_count + 1;
        end
    end

    // Slow reader; each read takes effect just after a write-clock edge,
    // as a synchronized read pointer would.
    initial begin
        forever begin
            @(posedge RCLK);
            if (fifo_mode && (wr_count > rd_count)) begin
                @(posedge CLK);
                #1;
                rx.push_back(mem[rd_count[7:0]]);
                rd_count++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input logic [DW-1:0] exp[$]);
        check({tag, "_count"}, 16'(dut_log.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            check({tag, "_word"}, 16'(dut_log[i]), 16'(exp[i]));
    endtask

    // One clock: predict and check outputs, advance the model, release a
    // requester whose handshake just completed.
    task automatic cycle();
        logic e_alu, e_rf, e_inc;
        logic [DW-1:0] e_data;
        @(negedge CLK);
        e_alu  = RST && !m_busy && ALU_VLD && (!RF_VLD || m_last_rf);
        e_rf   = RST && !m_busy && RF_VLD && (!ALU_VLD || !m_last_rf);
        e_inc  = RST && m_busy && !FIFO_FULL;
        e_data = m_busy ? m_q[0] : '0;
        check("ALU_RDY", 16'(ALU_RDY), 16'(e_alu));
        check("RF_RDY",  16'(RF_RDY),  16'(e_rf));
        check("WR_INC",  16'(WR_INC),  16'(e_inc));
        check("BUSY",    16'(BUSY),    16'(m_busy));
        check("WR_DATA", 16'(WR_DATA), 16'(e_data));
        if (m_busy && FIFO_FULL) stall_cycles++;
        if (!RST) begin
            m_busy    = 1'b0;
            m_last_rf = 1'b1;
            m_q.delete();
        end else if (m_busy) begin
            if (!FIFO_FULL) begin
                m_log.push_back(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
        end else if (e_alu) begin
            m_q.push_back(ALU_OUT[DW-1:0]);
            m_q.push_back(ALU_OUT[2*DW-1:DW]);
            m_busy    = 1'b1;
            m_last_rf = 1'b0;
        end else if (e_rf) begin
            m_q.push_back(RF_RD_DATA);
            m_busy    = 1'b1;
            m_last_rf = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (e_alu) ALU_VLD = 1'b0;
        if (e_rf)  RF_VLD  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        int guard;

        RST = 1'b0; ALU_OUT = '0; ALU_VLD = 1'b0; RF_RD_DATA = '0; RF_VLD = 1'b0;
        full_drv = 1'b0;
        @(posedge CLK); #1;
        run(3);                                   // reset state
        RST = 1'b1;

        // Single ALU message
        dut_log.delete();
        ALU_OUT = 16'hA55A; ALU_VLD = 1'b1;
        run(5);
        exp_q = '{8'h5A, 8'hA5};
        check_log("alu_single", exp_q);

        // Simultaneous requests from reset: ALU wins the first tie
        RST = 1'b0; run(2); RST = 1'b1;
        dut_log.delete();
        ALU_OUT = 16'h1234; ALU_VLD = 1'b1; RF_RD_DATA = 8'h77; RF_VLD = 1'b1;
        run(8);
        exp_q = '{8'h34, 8'h12, 8'h77};
        check_log("tie_from_reset", exp_q);

        // RF won last, so the next tie goes to the ALU
        dut_log.delete();
        ALU_OUT = 16'h5678; ALU_VLD = 1'b1; RF_RD_DATA = 8'h99; RF_VLD = 1'b1;
        run(8);
        exp_q = '{8'h78, 8'h56, 8'h99};
        check_log("tie_second", exp_q);

        // Full for three cycles right after acceptance
        dut_log.delete();
        ALU_OUT = 16'hBEEF; ALU_VLD = 1'b1;
        run(1);
        full_drv = 1'b1; run(3);
        full_drv = 1'b0; run(4);
        exp_q = '{8'hEF, 8'hBE};
        check_log("full_stall", exp_q);

        // Full pulse between the two words
        dut_log.delete();
        ALU_OUT = 16'hC0DE; ALU_VLD = 1'b1;
        run(1);
        full_drv = 1'b0; run(1);
        full_drv = 1'b1; run(1);
        full_drv = 1'b0; run(3);
        exp_q = '{8'hDE, 8'hC0};
        check_log("mid_stall", exp_q);

        // Reset after the first word of a message
        dut_log.delete();
        ALU_OUT = 16'h4242; ALU_VLD = 1'b1;
        run(2);
        RST = 1'b0; run(2);
        RST = 1'b1;
        RF_RD_DATA = 8'h11; RF_VLD = 1'b1;
        run(4);
        exp_q = '{8'h42, 8'h11};
        check_log("reset_mid", exp_q);

        // Back-to-back RF messages into a shallow FIFO with a slow reader
        stall_cycles = 0;
        fifo_mode = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            RF_RD_DATA = 8'(k); RF_VLD = 1'b1;
            guard = 0;
            while (RF_VLD && guard < 50) begin
                cycle();
                guard++;
            end
            check("rf_handshake_timeout", 16'(RF_VLD), 16'd0);
            RF_VLD = 1'b0;
        end
        guard = 0;
        while (rx.size() < 14 && guard < 200) begin
            cycle();
            guard++;
        end
        check("rx_count", 16'(rx.size()), 16'd14);
        for (int i = 0; i < rx.size(); i++)
            check("rx_word", 16'(rx[i]), 16'(i + 1));
        check("stall_seen", 16'(stall_cycles > 0), 16'd1);
        fifo_mode = 1'b0;

        // Randomized traffic with random full and occasional resets
        dut_log.delete();
        m_log.delete();
        repeat (400) begin
            if (!ALU_VLD && ($urandom % 3 == 0)) begin
                ALU_OUT = 16'($urandom); ALU_VLD = 1'b1;
            end
            if (!RF_VLD && ($urandom % 3 == 0)) begin
                RF_RD_DATA = 8'($urandom); RF_VLD = 1'b1;
            end
            full_drv = ($urandom % 4 == 0);
            RST      = ($urandom % 64 != 0);
            cycle();
        end
        RST = 1'b1; full_drv = 1'b0;
        run(10);
        check("rand_count", 16'(dut_log.size()), 16'(m_log.size()));
        for (int i = 0; i < m_log.size() && i < dut_log.size(); i++)
            check("rand_word", 16'(dut_log[i]), 16'(m_log[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
